ahb_master_arbiter: RTL and testbench

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

---
 rtl/ahb_master_arbiter_if.sv | 49 ++++
 rtl/ahb_master_arbiter.sv | 142 ++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_master_arbiter_if : per-master request bundle and shared AHB bus       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ahb_master_arbiter_if #(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [2*N_MASTERS-1:0]          m_htrans;
    logic [ADDR_WIDTH*N_MASTERS-1:0] m_haddr;
    logic [N_MASTERS-1:0]            m_hwrite;
    logic [3*N_MASTERS-1:0]          m_hsize;
    logic [3*N_MASTERS-1:0]          m_hburst;
    logic [4*N_MASTERS-1:0]          m_hprot;
    logic [DATA_WIDTH*N_MASTERS-1:0] m_hwdata;
    logic                            HREADY;
    logic [1:0]                      HRESP;

    logic [1:0]                      HTRANS;
    logic [ADDR_WIDTH-1:0]           HADDR;
    logic                            HWRITE;
    logic [2:0]                      HSIZE;
    logic [2:0]                      HBURST;
    logic [3:0]                      HPROT;
    logic [DATA_WIDTH-1:0]           HWDATA;
    logic [N_MASTERS-1:0]            m_hgrant;
    logic [2:0]                      HMASTER;
    logic [2:0]                      HMASTER_D;
    logic                            HMASTER_DV;

    // Bus environment side: masters and the shared slave.
    modport master (
        output m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_hwdata,
        output HREADY, HRESP,
        input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  m_hgrant, HMASTER, HMASTER_D, HMASTER_DV
    );

    // Arbiter side.
    modport slave (
        input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_hwdata,
        input  HREADY, HRESP,
        output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output m_hgrant, HMASTER, HMASTER_D, HMASTER_DV
    );
endinterface
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_master_arbiter : round-robin AHB multi-master arbiter with bus muxes   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ahb_master_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic           HCLK,
    input  wire logic           HRESETn,
    ahb_master_arbiter_if.slave bus
);
    localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_TRANS_SEQ    = 2'b11;
    localparam logic [2:0] c_BURST_SINGLE = 3'b000;
    localparam logic [1:0] c_RESP_ERROR   = 2'b01;

    logic [2:0]            owner_q, owner_d;
    logic [3:0]            beat_q, beat_d;
    logic [2:0]            data_owner_q, data_owner_d;
    logic                  data_valid_q, data_valid_d;

    logic [N_MASTERS-1:0]  w_req;
    logic [1:0]            w_own_trans;
    logic [ADDR_WIDTH-1:0] w_own_addr;
    logic                  w_own_write;
    logic [2:0]            w_own_size;
    logic [2:0]            w_own_burst;
    logic [3:0]            w_own_prot;
    logic [DATA_WIDTH-1:0] w_data_wdata;
    logic                  w_fixed;
    logic [3:0]            w_burst_last;
    logic                  w_arb_point;
    logic [2:0]            w_winner;

    always_comb begin
        w_req        = '0;
        w_own_trans  = bus.m_htrans[1:0];
        w_own_addr   = bus.m_haddr[ADDR_WIDTH-1:0];
        w_own_write  = bus.m_hwrite[0];
        w_own_size   = bus.m_hsize[2:0];
        w_own_burst  = bus.m_hburst[2:0];
        w_own_prot   = bus.m_hprot[3:0];
        w_data_wdata = bus.m_hwdata[DATA_WIDTH-1:0];
        for (int i = 0; i < N_MASTERS; i++) begin
            w_req[i] = (bus.m_htrans[2*i +: 2] == c_TRANS_NONSEQ);
            if (owner_q == 3'(i)) begin
                w_own_trans = bus.m_htrans[2*i +: 2];
                w_own_addr  = bus.m_haddr[ADDR_WIDTH*i +: ADDR_WIDTH];
                w_own_write = bus.m_hwrite[i];
                w_own_size  = bus.m_hsize[3*i +: 3];
                w_own_burst = bus.m_hburst[3*i +: 3];
                w_own_prot  = bus.m_hprot[4*i +: 4];
            end
            if (data_owner_q == 3'(i)) begin
                w_data_wdata = bus.m_hwdata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Fixed-length bursts end on beat index length-1; SINGLE and INCR never do here.
    always_comb begin
        w_fixed      = 1'b1;
        w_burst_last = 4'd0;
        case (w_own_burst)
            3'b010, 3'b011: w_burst_last = 4'd3;
            3'b100, 3'b101: w_burst_last = 4'd7;
            3'b110, 3'b111: w_burst_last = 4'd15;
            default:        w_fixed      = 1'b0;
        endcase
    end

    assign w_arb_point = bus.HREADY &&
                         ((bus.HRESP == c_RESP_ERROR) ||
                          (w_own_trans == c_TRANS_IDLE) ||
                          ((w_own_trans == c_TRANS_NONSEQ) && (w_own_burst == c_BURST_SINGLE)) ||
                          ((w_own_trans == c_TRANS_SEQ) && w_fixed && (beat_q == w_burst_last)));

    // Two descending passes: lowest requester above the owner beats any at or below it,
    // so the owner itself only wins when it is the sole requester.
    always_comb begin
        w_winner = owner_q;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_req[i] && (3'(i) <= owner_q)) w_winner = 3'(i);
        end
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_req[i] && (3'(i) > owner_q)) w_winner = 3'(i);
        end
    end

    always_comb begin
        owner_d      = owner_q;
        beat_d       = beat_q;
        data_owner_d = data_owner_q;
        data_valid_d = data_valid_q;
        if (bus.HREADY) begin
            data_owner_d = owner_q;
            data_valid_d = w_own_trans[1];
            if (w_arb_point) begin
                owner_d = w_winner;
                beat_d  = 4'd0;
            end else if (w_own_trans == c_TRANS_NONSEQ) begin
                beat_d  = 4'd1;
            end else if (w_own_trans == c_TRANS_SEQ) begin
                beat_d  = beat_q + 4'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q      <= 3'd0;
            beat_q       <= 4'd0;
            data_owner_q <= 3'd0;
            data_valid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bus.HTRANS     = w_own_trans;
    assign bus.HADDR      = w_own_addr;
    assign bus.HWRITE     = w_own_write;
    assign bus.HSIZE      = w_own_size;
    assign bus.HBURST     = w_own_burst;
    assign bus.HPROT      = w_own_prot;
    assign bus.HWDATA     = data_valid_q ? w_data_wdata : '0;
    assign bus.HMASTER    = owner_q;
    assign bus.HMASTER_D  = data_owner_q;
    assign bus.HMASTER_DV = data_valid_q;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_grant
        assign bus.m_hgrant[gi] = (owner_q == 3'(gi));
    end
endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ahb_master_arbiter : directed self-checking bench for the AHB arbiter   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ahb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] INCR16 = 3'b111;

    logic HCLK;
    logic HRESETn;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_master_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_master_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int i, input logic [1:0] tr, input logic [2:0] bu);
        bus.m_htrans[2*i +: 2] = tr;
        bus.m_hburst[3*i +: 3] = bu;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Owner 1 INCR8 with a BUSY before beat 3 and a two-cycle wait state on beat 5.
    logic [1:0] t8_trans [11] = '{NONSEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       t8_rdy   [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] t8_own   [11] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [3:0] t8_beat  [11] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7, 4'd0};
    logic       t8_dv    [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        HRESETn      = 1'b0;
        bus.HREADY   = 1'b1;
        bus.HRESP    = 2'b00;
        bus.m_htrans = '0;
        bus.m_hburst = '0;
        for (int i = 0; i < N; i++) begin
            bus.m_haddr[AW*i +: AW]  = 32'hA000_0000 + 32'(i);
            bus.m_hwdata[DW*i +: DW] = 32'hD000_0000 + 32'(i);
            bus.m_hsize[3*i +: 3]    = 3'(i);
            bus.m_hprot[4*i +: 4]    = 4'(i + 8);
            bus.m_hwrite[i]          = i[0];
        end
        repeat (2) tick();

        // Reset state
        check_eq("rst_hmaster", 64'(bus.HMASTER), 64'(0));
        check_eq("rst_grant", 64'(bus.m_hgrant), 64'(4'b0001));
        check_eq("rst_hmaster_d", 64'(bus.HMASTER_D), 64'(0));
        check_eq("rst_dv", 64'(bus.HMASTER_DV), 64'(0));
        check_eq("rst_beat", 64'(dut.beat_q), 64'(0));
        check_eq("rst_hwdata", 64'(bus.HWDATA), 64'(0));
        HRESETn = 1'b1;

        // Simple round robin between masters 1 and 2
        set_m(1, NONSEQ, SINGLE);
        set_m(2, NONSEQ, SINGLE);
        #1;
        check_eq("rr_htrans_own0", 64'(bus.HTRANS), 64'(IDLE));
        check_eq("rr_haddr_own0", 64'(bus.HADDR), 64'(32'hA000_0000));
        tick();
        check_eq("rr_hmaster_1", 64'(bus.HMASTER), 64'(1));
        check_eq("rr_grant_1", 64'(bus.m_hgrant), 64'(4'b0010));
        check_eq("rr_htrans_1", 64'(bus.HTRANS), 64'(NONSEQ));
        check_eq("rr_haddr_1", 64'(bus.HADDR), 64'(32'hA000_0001));
        check_eq("rr_hsize_1", 64'(bus.HSIZE), 64'(1));
        check_eq("rr_hprot_1", 64'(bus.HPROT), 64'(9));
        check_eq("rr_hwrite_1", 64'(bus.HWRITE), 64'(1));
        check_eq("rr_dv_idle", 64'(bus.HMASTER_DV), 64'(0));
        tick();
        check_eq("rr_hmaster_2", 64'(bus.HMASTER), 64'(2));
        check_eq("rr_hmaster_d_1", 64'(bus.HMASTER_D), 64'(1));
        check_eq("rr_dv_1", 64'(bus.HMASTER_DV), 64'(1));
        check_eq("rr_hwdata_1", 64'(bus.HWDATA), 64'(32'hD000_0001));
        tick();
        check_eq("rr_hmaster_d_2", 64'(bus.HMASTER_D), 64'(2));
        check_eq("rr_hmaster_back1", 64'(bus.HMASTER), 64'(1));
        check_eq("rr_hwdata_2", 64'(bus.HWDATA), 64'(32'hD000_0002));
        set_m(1, IDLE, SINGLE);
        set_m(2, IDLE, SINGLE);
        tick();
        check_eq("park_hmaster", 64'(bus.HMASTER), 64'(1));
        check_eq("park_dv", 64'(bus.HMASTER_DV), 64'(0));
        check_eq("park_hwdata", 64'(bus.HWDATA), 64'(0));

        // Owner 0 INCR4 with master 3 waiting
        set_m(0, NONSEQ, INCR4);
        tick();
        check_eq("i4_acquire", 64'(bus.HMASTER), 64'(0));
        check_eq("i4_beat_clr", 64'(dut.beat_q), 64'(0));
        set_m(3, NONSEQ, SINGLE);
        tick();
        check_eq("i4_own_b0", 64'(bus.HMASTER), 64'(0));
        check_eq("i4_beat_b0", 64'(dut.beat_q), 64'(1));
        set_m(0, SEQ, INCR4);
        for (int b = 1; b < 4; b++) begin
            tick();
            check_eq("i4_own", 64'(bus.HMASTER), 64'((b == 3) ? 3 : 0));
            check_eq("i4_beat", 64'(dut.beat_q), 64'((b == 3) ? 0 : b + 1));
        end
        check_eq("i4_grant_3", 64'(bus.m_hgrant), 64'(4'b1000));

        // Owner 1 INCR8 with BUSY and wait states, master 0 waiting
        set_m(3, IDLE, SINGLE);
        set_m(0, IDLE, SINGLE);
        set_m(1, NONSEQ, INCR8);
        tick();
        check_eq("i8_acquire", 64'(bus.HMASTER), 64'(1));
        set_m(0, NONSEQ, SINGLE);
        for (int c = 0; c < 11; c++) begin
            set_m(1, t8_trans[c], INCR8);
            bus.HREADY = t8_rdy[c];
            tick();
            check_eq("i8_own", 64'(bus.HMASTER), 64'(t8_own[c]));
            check_eq("i8_beat", 64'(dut.beat_q), 64'(t8_beat[c]));
            check_eq("i8_dv", 64'(bus.HMASTER_DV), 64'(t8_dv[c]));
        end
        bus.HREADY = 1'b1;

        // Owner 2 undefined INCR, 21 beats, master 0 waiting
        set_m(0, IDLE, SINGLE);
        set_m(1, IDLE, SINGLE);
        set_m(2, NONSEQ, INCR);
        tick();
        check_eq("incr_acquire", 64'(bus.HMASTER), 64'(2));
        set_m(0, NONSEQ, SINGLE);
        for (int b = 0; b < 21; b++) begin
            set_m(2, (b == 0) ? NONSEQ : SEQ, INCR);
            tick();
            check_eq("incr_hold", 64'(bus.HMASTER), 64'(2));
        end
        check_eq("incr_beat_wrap", 64'(dut.beat_q), 64'(5));
        set_m(2, IDLE, INCR);
        bus.HREADY = 1'b0;
        tick();
        check_eq("incr_wait_own", 64'(bus.HMASTER), 64'(2));
        check_eq("incr_wait_dv_hold", 64'(bus.HMASTER_DV), 64'(1));
        check_eq("incr_wait_d_hold", 64'(bus.HMASTER_D), 64'(2));
        bus.HREADY = 1'b1;
        tick();
        check_eq("incr_release", 64'(bus.HMASTER), 64'(0));
        check_eq("incr_release_dv", 64'(bus.HMASTER_DV), 64'(0));

        // Owner 0 INCR16 terminated by a two-cycle ERROR on beat 6
        set_m(0, NONSEQ, INCR16);
        set_m(1, NONSEQ, SINGLE);
        tick();
        check_eq("err_beat1", 64'(dut.beat_q), 64'(1));
        set_m(0, SEQ, INCR16);
        repeat (5) tick();
        check_eq("err_own_b6", 64'(bus.HMASTER), 64'(0));
        check_eq("err_beat6", 64'(dut.beat_q), 64'(6));
        bus.HRESP  = 2'b01;
        bus.HREADY = 1'b0;
        tick();
        check_eq("err_c1_own", 64'(bus.HMASTER), 64'(0));
        check_eq("err_c1_beat", 64'(dut.beat_q), 64'(6));
        bus.HREADY = 1'b1;
        tick();
        check_eq("err_c2_own", 64'(bus.HMASTER), 64'(1));
        check_eq("err_c2_beat", 64'(dut.beat_q), 64'(0));
        bus.HRESP = 2'b00;

        // Reset in the middle of an INCR8 owned by master 3
        set_m(0, IDLE, SINGLE);
        set_m(1, IDLE, SINGLE);
        set_m(3, NONSEQ, INCR8);
        tick();
        check_eq("rst8_acquire", 64'(bus.HMASTER), 64'(3));
        tick();
        set_m(3, SEQ, INCR8);
        repeat (2) tick();
        check_eq("rst8_beat3", 64'(dut.beat_q), 64'(3));
        check_eq("rst8_d3", 64'(bus.HMASTER_D), 64'(3));
        #3;
        HRESETn = 1'b0;
        #1;
        check_eq("rst8_hmaster", 64'(bus.HMASTER), 64'(0));
        check_eq("rst8_grant", 64'(bus.m_hgrant), 64'(4'b0001));
        check_eq("rst8_dv", 64'(bus.HMASTER_DV), 64'(0));
        check_eq("rst8_d", 64'(bus.HMASTER_D), 64'(0));
        check_eq("rst8_beat", 64'(dut.beat_q), 64'(0));
        check_eq("rst8_hwdata", 64'(bus.HWDATA), 64'(0));
        #2;
        HRESETn = 1'b1;
        set_m(3, IDLE, SINGLE);
        set_m(2, NONSEQ, SINGLE);
        tick();
        check_eq("post_rst_hmaster", 64'(bus.HMASTER), 64'(2));
        check_eq("post_rst_grant", 64'(bus.m_hgrant), 64'(4'b0100));
        check_eq("post_rst_haddr", 64'(bus.HADDR), 64'(32'hA000_0002));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
